// File: rtl/pipelined_alu_core_param_if.sv
// Instruction/result handshake bundle for pipelined_alu_core_param.
// The master side issues instructions and consumes results; the core is the slave.
interface pipelined_alu_core_param_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
);
    localparam int AW = $clog2(NREGS);

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [AW-1:0]     instr_rd;
    logic [AW-1:0]     instr_rs1;
    logic [AW-1:0]     instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] aluout;
    logic [AW-1:0]     out_rd;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, flush, out_ready,
        input  instr_ready, out_valid, aluout, out_rd
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, flush, out_ready,
        output instr_ready, out_valid, aluout, out_rd
    );
endinterface

// File: rtl/pipelined_alu_core_param.sv
// Four-stage in-order ALU core (latch / operand read / execute / writeback) with
// a register file, two-level operand forwarding, output backpressure and flush.
module pipelined_alu_core_param #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_alu_core_param_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SH = $clog2(DATA_W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef logic signed [DATA_W-1:0] word_t;

    function automatic word_t alu_f(input logic [2:0] op, input word_t a, input word_t b,
                                    input word_t imm);
        word_t r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = (a < b) ? word_t'(1) : '0;
            OP_SLL:  r = a << b[SH-1:0];
            default: r = imm;
        endcase
        return r;
    endfunction

    // Youngest producer wins: the instruction in S2 is newer than the one in S3.
    function automatic word_t operand_f(input logic [AW-1:0] idx, input word_t rf_val,
                                        input logic vld_s2, input logic [AW-1:0] rd_s2,
                                        input word_t alu_s2, input logic vld_s3,
                                        input logic [AW-1:0] rd_s3, input word_t res_s3);
        word_t v;
        if (idx == '0)                       v = '0;
        else if (vld_s2 && (rd_s2 == idx))   v = alu_s2;
        else if (vld_s3 && (rd_s3 == idx))   v = res_s3;
        else                                 v = rf_val;
        return v;
    endfunction

    // S1: instruction latch
    logic          vld_p0_q, vld_p0_d;
    logic [2:0]    op_p0_q, op_p0_d;
    logic [AW-1:0] rd_p0_q, rd_p0_d;
    logic [AW-1:0] rs1_p0_q, rs1_p0_d;
    logic [AW-1:0] rs2_p0_q, rs2_p0_d;
    word_t         imm_p0_q, imm_p0_d;
    // S2: operand registers
    logic          vld_p1_q, vld_p1_d;
    logic [2:0]    op_p1_q, op_p1_d;
    logic [AW-1:0] rd_p1_q, rd_p1_d;
    word_t         a_p1_q, a_p1_d;
    word_t         b_p1_q, b_p1_d;
    word_t         imm_p1_q, imm_p1_d;
    // S3: ALU result
    logic          vld_p2_q, vld_p2_d;
    logic [AW-1:0] rd_p2_q, rd_p2_d;
    word_t         res_p2_q, res_p2_d;
    // S4: output / retired result
    logic          vld_p3_q, vld_p3_d;
    logic [AW-1:0] rd_p3_q, rd_p3_d;
    word_t         res_p3_q, res_p3_d;

    word_t regs_q [NREGS];
    word_t regs_d [NREGS];

    logic  stall;
    logic  accept;
    word_t alu_p1;
    word_t opa_p0;
    word_t opb_p0;

    assign stall  = vld_p3_q & ~bus.out_ready;
    assign accept = bus.instr_valid & ~stall & ~bus.flush;

    assign alu_p1 = alu_f(op_p1_q, a_p1_q, b_p1_q, imm_p1_q);
    assign opa_p0 = operand_f(rs1_p0_q, regs_q[rs1_p0_q], vld_p1_q, rd_p1_q, alu_p1,
                              vld_p2_q, rd_p2_q, res_p2_q);
    assign opb_p0 = operand_f(rs2_p0_q, regs_q[rs2_p0_q], vld_p1_q, rd_p1_q, alu_p1,
                              vld_p2_q, rd_p2_q, res_p2_q);

    assign bus.instr_ready = ~stall & ~bus.flush;
    assign bus.out_valid   = vld_p3_q;
    assign bus.aluout      = res_p3_q;
    assign bus.out_rd      = rd_p3_q;

    always_comb begin
        vld_p0_d = vld_p0_q;
        op_p0_d  = op_p0_q;
        rd_p0_d  = rd_p0_q;
        rs1_p0_d = rs1_p0_q;
        rs2_p0_d = rs2_p0_q;
        imm_p0_d = imm_p0_q;
        vld_p1_d = vld_p1_q;
        op_p1_d  = op_p1_q;
        rd_p1_d  = rd_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        imm_p1_d = imm_p1_q;
        vld_p2_d = vld_p2_q;
        rd_p2_d  = rd_p2_q;
        res_p2_d = res_p2_q;
        vld_p3_d = vld_p3_q;
        rd_p3_d  = rd_p3_q;
        res_p3_d = res_p3_q;
        regs_d   = regs_q;

        if (!stall) begin
            vld_p0_d = accept;
            if (accept) begin
                op_p0_d  = bus.instr_op;
                rd_p0_d  = bus.instr_rd;
                rs1_p0_d = bus.instr_rs1;
                rs2_p0_d = bus.instr_rs2;
                imm_p0_d = bus.instr_imm;
            end

            vld_p1_d = vld_p0_q;
            op_p1_d  = op_p0_q;
            rd_p1_d  = rd_p0_q;
            imm_p1_d = imm_p0_q;
            a_p1_d   = opa_p0;
            b_p1_d   = opb_p0;

            vld_p2_d = vld_p1_q;
            rd_p2_d  = rd_p1_q;
            res_p2_d = alu_p1;

            // A flushed S3 instruction neither retires nor writes back.
            vld_p3_d = vld_p2_q & ~bus.flush;
            if (vld_p2_q && !bus.flush) begin
                res_p3_d = res_p2_q;
                rd_p3_d  = rd_p2_q;
                if (rd_p2_q != '0) begin
                    regs_d[rd_p2_q] = res_p2_q;
                end
            end
        end

        // Flush kills S1-S3 even while the output is stalled; S4 is left alone.
        if (bus.flush) begin
            vld_p0_d = 1'b0;
            vld_p1_d = 1'b0;
            vld_p2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0_q <= 1'b0;
            op_p0_q  <= '0;
            rd_p0_q  <= '0;
            rs1_p0_q <= '0;
            rs2_p0_q <= '0;
            imm_p0_q <= '0;
            vld_p1_q <= 1'b0;
            op_p1_q  <= '0;
            rd_p1_q  <= '0;
            a_p1_q   <= '0;
            b_p1_q   <= '0;
            imm_p1_q <= '0;
            vld_p2_q <= 1'b0;
            rd_p2_q  <= '0;
            res_p2_q <= '0;
            vld_p3_q <= 1'b0;
            rd_p3_q  <= '0;
            res_p3_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            vld_p0_q <= vld_p0_d;
            op_p0_q  <= op_p0_d;
            rd_p0_q  <= rd_p0_d;
            rs1_p0_q <= rs1_p0_d;
            rs2_p0_q <= rs2_p0_d;
            imm_p0_q <= imm_p0_d;
            vld_p1_q <= vld_p1_d;
            op_p1_q  <= op_p1_d;
            rd_p1_q  <= rd_p1_d;
            a_p1_q   <= a_p1_d;
            b_p1_q   <= b_p1_d;
            imm_p1_q <= imm_p1_d;
            vld_p2_q <= vld_p2_d;
            rd_p2_q  <= rd_p2_d;
            res_p2_q <= res_p2_d;
            vld_p3_q <= vld_p3_d;
            rd_p3_q  <= rd_p3_d;
            res_p3_q <= res_p3_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_alu_core_param.sv
// Bench for pipelined_alu_core_param: directed scenarios plus random traffic
// scored against an in-order architectural model with flush rollback.
module tb_pipelined_alu_core_param;
    localparam int DW = 32;
    localparam int NR = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_LI  = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipelined_alu_core_param_if #(.DATA_W(DW), .NREGS(NR)) bus ();
    pipelined_alu_core_param #(.DATA_W(DW), .NREGS(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Each pending instruction carries its expected result and the architectural
    // register state after it, so a flush can roll the model back.
    typedef struct packed {
        logic [2:0]       rd;
        logic [31:0]      res;
        logic [7:0][31:0] after;
    } ent_t;

    ent_t             exp_q[$];
    logic [7:0][31:0] mreg;
    logic [7:0][31:0] creg;
    logic [31:0]      got[$];
    logic [2:0]       got_rd[$];
    int               checks = 0;
    int               errors = 0;
    logic             s_ready, s_ov;
    logic [31:0]      s_alu;
    logic [2:0]       s_rd;
    logic             ov_h  [16];
    logic             rdy_h [16];
    logic [31:0]      alu_h [16];
    int               n;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] imm);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a << (b % 32);
            default: return imm;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm,
                       input logic ordy, input logic fl);
        logic acc, ret;
        @(negedge clk);
        bus.instr_valid = v;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_imm   = imm;
        bus.out_ready   = ordy;
        bus.flush       = fl;
        #1;
        s_ready = bus.instr_ready;
        s_ov    = bus.out_valid;
        s_alu   = bus.aluout;
        s_rd    = bus.out_rd;
        chk("ready_rule", 32'(s_ready), 32'(!(s_ov && !ordy) && !fl));
        acc = v && s_ready;
        ret = s_ov && ordy;
        if (ret) begin
            got.push_back(s_alu);
            got_rd.push_back(s_rd);
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 32'(s_ov), 32'd0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("retire_data", s_alu, e.res);
                chk("retire_rd", 32'(s_rd), 32'(e.rd));
                creg = e.after;
            end
        end
        if (fl) begin
            if (s_ov && !ret && exp_q.size() != 0) begin
                ent_t h;
                h = exp_q[0];
                exp_q.delete();
                exp_q.push_back(h);
                mreg = h.after;
            end else begin
                exp_q.delete();
                mreg = creg;
            end
        end
        if (acc) begin
            ent_t e;
            e.res = ref_result(op, mreg[rs1], mreg[rs2], imm);
            e.rd  = rd;
            if (rd != 3'd0) mreg[rd] = e.res;
            e.after = mreg;
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_aluout", bus.aluout, 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        mreg = '0;
        creg = '0;
        got.delete();
        got_rd.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.instr_imm   = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        mreg = '0;
        creg = '0;

        // Back-to-back dependency chain with out_ready held high
        do_reset();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: cyc(1'b1, OP_LI,  3'd1, 3'd0, 3'd0, 32'd5, 1'b1, 1'b0);
                1: cyc(1'b1, OP_LI,  3'd2, 3'd0, 3'd0, 32'd7, 1'b1, 1'b0);
                2: cyc(1'b1, OP_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b1, 1'b0);
                3: cyc(1'b1, OP_SUB, 3'd4, 3'd3, 3'd1, 32'd0, 1'b1, 1'b0);
                default: idle(1);
            endcase
            ov_h[i]  = s_ov;
            alu_h[i] = s_alu;
        end
        chk("dep_lat_before", 32'(ov_h[3]), 32'd0);
        chk("dep_v0", 32'(ov_h[4]), 32'd1);
        chk("dep_r0", alu_h[4], 32'd5);
        chk("dep_v1", 32'(ov_h[5]), 32'd1);
        chk("dep_r1", alu_h[5], 32'd7);
        chk("dep_v2", 32'(ov_h[6]), 32'd1);
        chk("dep_r2", alu_h[6], 32'd12);
        chk("dep_v3", 32'(ov_h[7]), 32'd1);
        chk("dep_r3", alu_h[7], 32'd7);
        chk("dep_drained", 32'(ov_h[8]), 32'd0);

        // Same stream with three cycles of backpressure after the first result
        do_reset();
        for (int i = 0; i < 14; i++) begin
            case (i)
                0: cyc(1'b1, OP_LI,  3'd1, 3'd0, 3'd0, 32'd5, 1'b1, 1'b0);
                1: cyc(1'b1, OP_LI,  3'd2, 3'd0, 3'd0, 32'd7, 1'b1, 1'b0);
                2: cyc(1'b1, OP_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b1, 1'b0);
                3: cyc(1'b1, OP_SUB, 3'd4, 3'd3, 3'd1, 32'd0, 1'b1, 1'b0);
                4, 5, 6: cyc(1'b1, OP_LI, 3'd5, 3'd0, 3'd0, 32'd99, 1'b0, 1'b0);
                default: idle(1);
            endcase
            rdy_h[i] = s_ready;
            alu_h[i] = s_alu;
        end
        for (int i = 4; i < 7; i++) begin
            chk("bp_ready_low", 32'(rdy_h[i]), 32'd0);
            chk("bp_hold", alu_h[i], 32'd5);
        end
        chk("bp_count", got.size(), 32'd4);
        chk("bp_seq0", got[0], 32'd5);
        chk("bp_seq1", got[1], 32'd7);
        chk("bp_seq2", got[2], 32'd12);
        chk("bp_seq3", got[3], 32'd7);

        // Flush while LI r5 sits in S2
        do_reset();
        cyc(1'b1, OP_LI, 3'd5, 3'd0, 3'd0, 32'd9, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 32'd0, 1'b1, 1'b1);
        chk("flush_ready_low", 32'(s_ready), 32'd0);
        cyc(1'b1, OP_ADD, 3'd6, 3'd5, 3'd0, 32'd0, 1'b1, 1'b0);
        idle(6);
        chk("flush_count", got.size(), 32'd1);
        chk("flush_add", got[0], 32'd0);
        chk("flush_rd", 32'(got_rd[0]), 32'd6);

        // Width and signedness corners
        do_reset();
        cyc(1'b1, OP_LI,  3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cyc(1'b1, OP_LI,  3'd7, 3'd0, 3'd0, 32'd33, 1'b1, 1'b0);
        cyc(1'b1, OP_ADD, 3'd2, 3'd1, 3'd1, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, OP_SLT, 3'd3, 3'd1, 3'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, OP_SLL, 3'd4, 3'd1, 3'd7, 32'd0, 1'b1, 1'b0);
        idle(8);
        chk("wid_count", got.size(), 32'd5);
        chk("wid_add", got[2], 32'hFFFF_FFFE);
        chk("wid_slt", got[3], 32'd1);
        chk("wid_sll", got[4], 32'hFFFF_FFFE);

        // Register 0 is hard-wired to zero
        do_reset();
        cyc(1'b1, OP_LI,  3'd0, 3'd0, 3'd0, 32'd3, 1'b1, 1'b0);
        cyc(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0);
        idle(6);
        chk("r0_li", got[0], 32'd3);
        chk("r0_li_rd", 32'(got_rd[0]), 32'd0);
        chk("r0_add", got[1], 32'd0);

        // Asynchronous reset with instructions in flight
        do_reset();
        cyc(1'b1, OP_LI, 3'd1, 3'd0, 3'd0, 32'd4, 1'b1, 1'b0);
        cyc(1'b1, OP_LI, 3'd2, 3'd0, 3'd0, 32'd5, 1'b1, 1'b0);
        cyc(1'b1, OP_LI, 3'd3, 3'd0, 3'd0, 32'd6, 1'b1, 1'b0);
        cyc(1'b1, OP_LI, 3'd4, 3'd0, 3'd0, 32'd7, 1'b1, 1'b0);
        #1;
        chk("mid_pre_ov", 32'(bus.out_valid), 32'd1);
        chk("mid_pre_alu", bus.aluout, 32'd4);
        bus.instr_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_alu", bus.aluout, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        mreg = '0;
        creg = '0;
        got.delete();
        got_rd.delete();
        cyc(1'b1, OP_ADD, 3'd1, 3'd1, 3'd1, 32'd0, 1'b1, 1'b0);
        idle(6);
        chk("mid_count", got.size(), 32'd1);
        chk("mid_add", got[0], 32'd0);

        // Random traffic with backpressure and occasional flush
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            idle(1);
            n++;
        end
        chk("rand_drain", exp_q.size(), 32'd0);
        idle(1);
        chk("rand_idle", 32'(s_ov), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
